// File: rtl/ili9341_pkg.sv
// Shared constants, state encoding and the preamble byte table for the ILI9341 frame sequencer.
package ili9341_pkg;

   localparam logic [7:0]  CMD_CASET    = 8'h2A;
   localparam logic [7:0]  CMD_PASET    = 8'h2B;
   localparam logic [7:0]  CMD_RAMWR    = 8'h2C;
   localparam int unsigned PREAMBLE_LEN = 11;

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StPixHi,
      StPixLo,
      StDone
   } seq_state_e;

   // Window is always the full panel, so start coordinates are zero.
   function automatic logic [7:0] preamble_byte(input logic [3:0]  idx,
                                                input logic [15:0] wmax,
                                                input logic [15:0] hmax);
      case (idx)
         4'd0:    return CMD_CASET;
         4'd3:    return wmax[15:8];
         4'd4:    return wmax[7:0];
         4'd5:    return CMD_PASET;
         4'd8:    return hmax[15:8];
         4'd9:    return hmax[7:0];
         4'd10:   return CMD_RAMWR;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic preamble_dc(input logic [3:0] idx);
      return !(idx == 4'd0 || idx == 4'd5 || idx == 4'd10);
   endfunction

endpackage

// File: rtl/scan_counter.sv
// Row-major x/y pixel coordinate counter with enable, synchronous clear and last-pixel flag.
module scan_counter #(
   parameter int unsigned WIDTH  = 240,
   parameter int unsigned HEIGHT = 320,
   parameter int unsigned XW     = $clog2(WIDTH) + 1,
   parameter int unsigned YW     = $clog2(HEIGHT) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
   localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (x == XMAX) begin
            x <= '0;
            y <= (y == YMAX) ? '0 : y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   assign last = (x == XMAX) && (y == YMAX);

endmodule

// File: rtl/ili9341_frame_sequencer.sv
// Emits CASET/PASET/RAMWR then one RGB565 frame as a valid/ready byte stream.
// Define FRAME_SEQ_CONTINUOUS_EN to chain frames back to back while start stays high.
module ili9341_frame_sequencer
   import ili9341_pkg::*;
#(
   parameter  int unsigned WIDTH  = 240,
   parameter  int unsigned HEIGHT = 320,
   localparam int unsigned XW     = $clog2(WIDTH) + 1,
   localparam int unsigned YW     = $clog2(HEIGHT) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          frame_done,
   output logic [7:0]    byte_out,
   output logic          byte_dc,
   output logic          byte_valid,
   input  logic          byte_ready,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   input  logic [15:0]   pix_data
);

   localparam logic [15:0] WMAX     = 16'(WIDTH - 1);
   localparam logic [15:0] HMAX     = 16'(HEIGHT - 1);
   localparam logic [3:0]  IDX_LAST = 4'(PREAMBLE_LEN - 1);

   seq_state_e state;
   logic [3:0] idx;
   logic [7:0] byte_q;
   logic       xfer;
   logic       last_pix;
   logic       cnt_en;
   logic       cnt_clr;

   assign xfer    = byte_valid && byte_ready;
   assign cnt_en  = (state == StPixLo) && xfer;
   assign cnt_clr = (state == StPreamble) && xfer && (idx == IDX_LAST);

   // High byte passes straight from the source so a coordinate step costs no bubble.
   assign byte_out = (state == StPixHi) ? pix_data[15:8] : byte_q;

   scan_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .XW     (XW),
      .YW     (YW)
   ) u_scan (
      .clk   (clk),
      .reset (reset),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .x     (pix_x),
      .y     (pix_y),
      .last  (last_pix)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         idx        <= '0;
         byte_q     <= 8'h00;
         byte_dc    <= 1'b0;
         byte_valid <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  state      <= StPreamble;
                  idx        <= '0;
                  byte_q     <= CMD_CASET;
                  byte_dc    <= 1'b0;
                  byte_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            StPreamble: begin
               if (xfer) begin
                  if (idx == IDX_LAST) begin
                     state   <= StPixHi;
                     byte_dc <= 1'b1;
                  end else begin
                     idx     <= idx + 4'd1;
                     byte_q  <= preamble_byte(idx + 4'd1, WMAX, HMAX);
                     byte_dc <= preamble_dc(idx + 4'd1);
                  end
               end
            end
            StPixHi: begin
               if (xfer) begin
                  byte_q <= pix_data[7:0];
                  state  <= StPixLo;
               end
            end
            StPixLo: begin
               if (xfer) begin
                  if (last_pix) begin
                     state      <= StDone;
                     byte_valid <= 1'b0;
                     byte_dc    <= 1'b0;
                     frame_done <= 1'b1;
`ifdef FRAME_SEQ_CONTINUOUS_EN
                     busy       <= start;
`else
                     busy       <= 1'b0;
`endif
                  end else begin
                     state <= StPixHi;
                  end
               end
            end
            StDone: begin
`ifdef FRAME_SEQ_CONTINUOUS_EN
               if (start) begin
                  state      <= StPreamble;
                  idx        <= '0;
                  byte_q     <= CMD_CASET;
                  byte_dc    <= 1'b0;
                  byte_valid <= 1'b1;
                  busy       <= 1'b1;
               end else begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
`else
               state <= StIdle;
`endif
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ili9341_frame_sequencer.sv
// Scoreboard bench for ili9341_frame_sequencer at WIDTH=4, HEIGHT=2.
module tb_ili9341_frame_sequencer;

   localparam int unsigned W = 4;
   localparam int unsigned H = 2;

   typedef struct {
      logic       dc;
      logic [7:0] b;
      bit         xy;
      int         x;
      int         y;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        frame_done;
   logic [7:0]  byte_out;
   logic        byte_dc;
   logic        byte_valid;
   logic        byte_ready;
   logic [2:0]  pix_x;
   logic [1:0]  pix_y;
   logic [15:0] pix_data;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_xfer = 0;
   int   done_seen = 0;
   int   done_cyc = 0;
   int   s_cyc = 0;
   exp_t exp_q[$];

   logic [7:0] pre_b  [11] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h03,
                               8'h2B, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C};
   bit         pre_dc [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   // Pixel source: high byte C0|x, low byte 30|y.
   assign pix_data = {4'hC, 1'b0, pix_x, 4'h3, 2'b00, pix_y};

   ili9341_frame_sequencer #(
      .WIDTH  (W),
      .HEIGHT (H)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .byte_out   (byte_out),
      .byte_dc    (byte_dc),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_data   (pix_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total = total + 1;
      if (act !== req) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_frame(input int n);
      exp_t e;
      int   p;
      for (int k = 0; k < n; k++) begin
         if (k < 11) begin
            e.dc = pre_dc[k];
            e.b  = pre_b[k];
            e.xy = 0;
            e.x  = 0;
            e.y  = 0;
         end else begin
            p    = (k - 11) / 2;
            e.x  = p % W;
            e.y  = p / W;
            e.dc = 1'b1;
            e.xy = 1;
            e.b  = ((k - 11) % 2 == 0) ? (8'hC0 | 8'(e.x)) : (8'h30 | 8'(e.y));
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input int n);
      for (int i = 0; i < 300 && done_seen < n; i++) @(posedge clk);
      #1;
      check("frame_done_count", done_seen, n);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      s_cyc = cyc;
      start = 1'b0;
   endtask

   // Monitor: a transfer seen mid-cycle commits at the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (frame_done) begin
            done_seen = done_seen + 1;
            done_cyc  = cyc;
            check("done_after_last_xfer", cyc, last_xfer);
         end
         if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
               total = total + 1;
               bad   = bad + 1;
               $display("FAIL extra_byte: got %0h dc=%0b, expected none", byte_out, byte_dc);
            end else begin
               e = exp_q.pop_front();
               check("byte_dc_out", {byte_dc, byte_out}, {e.dc, e.b});
               check("busy_during_xfer", busy, 1'b1);
               if (e.xy) begin
                  check("pix_x", pix_x, e.x);
                  check("pix_y", pix_y, e.y);
               end
            end
            last_xfer = cyc + 1;
         end
      end
   end

   initial begin
      int base;
      reset      = 1'b0;
      start      = 1'b0;
      byte_ready = 1'b1;
      #1 reset = 1'b1;
      #2;
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_valid", byte_valid, 1'b0);
      check("rst_byte", byte_out, 8'h00);
      check("rst_dc", byte_dc, 1'b0);
      check("rst_pix_x", pix_x, 0);
      check("rst_pix_y", pix_y, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Free-running frame
      check("idle_valid", byte_valid, 1'b0);
      push_frame(27);
      pulse_start();
      check("lat_valid", byte_valid, 1'b1);
      check("lat_busy", busy, 1'b1);
      check("lat_byte", byte_out, 8'h2A);
      check("lat_dc", byte_dc, 1'b0);
      wait_done(1);
      check("done_edge", done_cyc, s_cyc + 27);
      check("post_busy", busy, 1'b0);
      check("post_valid", byte_valid, 1'b0);
      check("post_pix_x", pix_x, 0);
      check("post_pix_y", pix_y, 0);
      base = 1;

`ifndef FRAME_SEQ_CONTINUOUS_EN
      // start during preamble and during DONE must not queue another frame
      push_frame(27);
      pulse_start();
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (23) @(posedge clk);
      #1;
      check("done_pulse_now", frame_done, 1'b1);
      check("done_busy_low", busy, 1'b0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("no_second_frame", done_seen, base + 1);
      check("ignored_busy", busy, 1'b0);
      check("ignored_valid", byte_valid, 1'b0);
      base = base + 1;
`endif

      // Backpressure on the high byte of (2,1)
      push_frame(27);
      pulse_start();
      repeat (23) @(posedge clk);
      #1 byte_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("bp_valid", byte_valid, 1'b1);
         check("bp_byte", byte_out, 8'hC2);
         check("bp_dc", byte_dc, 1'b1);
         check("bp_pix_x", pix_x, 2);
         check("bp_pix_y", pix_y, 1);
         @(posedge clk);
         #1;
      end
      byte_ready = 1'b1;
      wait_done(base + 1);
      base = base + 1;

      // Reset while the low byte of (1,1) is presented
      push_frame(22);
      pulse_start();
      repeat (22) @(posedge clk);
      #1;
      check("pre_rst_pix_x", pix_x, 1);
      check("pre_rst_pix_y", pix_y, 1);
      check("pre_rst_byte", byte_out, 8'h31);
      reset = 1'b1;
      #1;
      check("abort_valid", byte_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_queue", exp_q.size(), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", done_seen, base);
      push_frame(27);
      pulse_start();
      check("restart_byte", byte_out, 8'h2A);
      wait_done(base + 1);
      base = base + 1;

`ifdef FRAME_SEQ_CONTINUOUS_EN
      // start held: frames chain; dropping it ends after the current frame
      push_frame(27);
      push_frame(27);
      start = 1'b1;
      wait_done(base + 1);
      check("cont_valid", byte_valid, 1'b1);
      check("cont_byte", byte_out, 8'h2A);
      check("cont_busy", busy, 1'b1);
      repeat (5) @(posedge clk);
      #1 start = 1'b0;
      wait_done(base + 2);
      check("cont_end_valid", byte_valid, 1'b0);
      check("cont_end_busy", busy, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("cont_stays_idle", done_seen, base + 2);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
